// File: rtl/imem_pkg.sv
// Shared types, boot image and parity helper for the instruction memory.
package imem_pkg;

  typedef enum logic [0:0] {BOOT, READY} imem_state_e;

  localparam int unsigned BootImgLen = 16;
  // Widest word the parity helper covers; narrower words are zero-extended.
  localparam int unsigned ParMaxW    = 256;

  localparam logic [31:0] BOOT_IMAGE [BootImgLen] = '{
    32'h6842000A, 32'h6885FFF0, 32'h48C81100, 32'h0FC64000,
    32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0,
    32'h0, 32'h0, 32'h0, 32'h0
  };

  // Even parity bit: XOR of all data bits, so {parity, word} has zero reduction XOR.
  function automatic logic even_parity(input logic [ParMaxW-1:0] word);
    return ^word;
  endfunction

endpackage

// File: rtl/imem_array.sv
// DEPTH-word storage with one write port and a registered read-first read port.
// With IMEM_PARITY_EN defined each word carries an even-parity bit checked on read.
module imem_array
  import imem_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned IDX_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [IDX_W-1:0]  widx,
  input  logic [DATA_W-1:0] wdata,
  input  logic              rd_hit,
  input  logic              rd_miss,
  input  logic [IDX_W-1:0]  ridx,
  output logic [DATA_W-1:0] rdata,
  output logic              rperr
);

`ifdef IMEM_PARITY_EN
  localparam int unsigned MemW = DATA_W + 1;
`else
  localparam int unsigned MemW = DATA_W;
`endif

  logic [MemW-1:0]   mem_q [DEPTH];
  logic [MemW-1:0]   wword;
  logic [DATA_W-1:0] rdata_q;

  always_comb begin
`ifdef IMEM_PARITY_EN
    wword = {even_parity(ParMaxW'(wdata)), wdata};
`else
    wword = wdata;
`endif
  end

  // Contents survive reset; only the boot copy rewrites the low words.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[widx] <= wword;
    end
  end

  // Non-blocking read of mem_q gives read-first behaviour on a same-address write.
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_q <= '0;
    end else if (rd_hit) begin
      rdata_q <= mem_q[ridx][DATA_W-1:0];
    end else if (rd_miss) begin
      rdata_q <= '0;
    end
  end

  assign rdata = rdata_q;

`ifdef IMEM_PARITY_EN
  logic rperr_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      rperr_q <= 1'b0;
    end else begin
      rperr_q <= rd_hit & (^mem_q[ridx]);
    end
  end

  assign rperr = rperr_q;
`else
  assign rperr = 1'b0;
`endif

endmodule

// File: rtl/imem_ctrl.sv
// Instruction memory controller: boot-copy FSM, port gating and range checks.
// Optional parity storage/checking is enabled by defining IMEM_PARITY_EN.
module imem_ctrl
  import imem_pkg::*;
#(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 16,
  parameter int unsigned DEPTH    = 256,
  parameter int unsigned BOOT_LEN = 4
) (
  input  logic              clk,
  input  logic              reset,
  output logic              boot_done,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_valid,
  output logic [DATA_W-1:0] fetch_data,
  output logic              fetch_fault,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_fault,
  output logic              parity_err
);

  localparam int unsigned     IdxW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // One extra bit so DEPTH == 2**ADDR_W is representable.
  localparam logic [ADDR_W:0] DepthLim = (ADDR_W + 1)'(DEPTH);

  imem_state_e state_q, state_d;
  logic [3:0]  boot_cnt_q, boot_cnt_d;

  logic              boot_wr;
  logic              fetch_ok, fetch_in_rng;
  logic              wr_ok, wr_in_rng;
  logic              arr_we;
  logic [IdxW-1:0]   arr_widx;
  logic [DATA_W-1:0] arr_wdata;
  logic              fetch_valid_q, fetch_fault_q, wr_fault_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= BOOT;
      boot_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      boot_cnt_q <= boot_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    boot_cnt_d = boot_cnt_q;
    unique case (state_q)
      BOOT: begin
        boot_cnt_d = boot_cnt_q + 4'd1;
        if (boot_cnt_q == 4'(BOOT_LEN - 1)) begin
          state_d = READY;
        end
      end
      READY: begin
        state_d = READY;
      end
      default: begin
        state_d = BOOT;
      end
    endcase
  end

  always_comb begin
    boot_done    = (state_q == READY);
    boot_wr      = (state_q == BOOT);
    fetch_in_rng = ({1'b0, fetch_addr} < DepthLim);
    wr_in_rng    = ({1'b0, wr_addr} < DepthLim);
    fetch_ok     = fetch_req & boot_done;
    wr_ok        = wr_en & boot_done;
    // Boot copy owns the write port; nothing is written on a reset edge.
    arr_we       = ~reset & (boot_wr | (wr_ok & wr_in_rng));
    arr_widx     = boot_wr ? IdxW'(boot_cnt_q) : wr_addr[IdxW-1:0];
    arr_wdata    = boot_wr ? DATA_W'(BOOT_IMAGE[boot_cnt_q]) : wr_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_valid_q <= 1'b0;
      fetch_fault_q <= 1'b0;
      wr_fault_q    <= 1'b0;
    end else begin
      fetch_valid_q <= fetch_ok;
      wr_fault_q    <= wr_ok & ~wr_in_rng;
      if (fetch_ok) begin
        fetch_fault_q <= ~fetch_in_rng;
      end
    end
  end

  assign fetch_valid = fetch_valid_q;
  assign fetch_fault = fetch_fault_q;
  assign wr_fault    = wr_fault_q;

  imem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IdxW)
  ) u_array (
    .clk     (clk),
    .reset   (reset),
    .we      (arr_we),
    .widx    (arr_widx),
    .wdata   (arr_wdata),
    .rd_hit  (fetch_ok & fetch_in_rng),
    .rd_miss (fetch_ok & ~fetch_in_rng),
    .ridx    (fetch_addr[IdxW-1:0]),
    .rdata   (fetch_data),
    .rperr   (parity_err)
  );

endmodule

// File: tb/tb_imem_ctrl.sv
// Self-checking bench for imem_ctrl (default parameters) against a word-level model.
module tb_imem_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        boot_done;
  logic        fetch_req = 1'b0;
  logic [15:0] fetch_addr = '0;
  logic        fetch_valid;
  logic [31:0] fetch_data;
  logic        fetch_fault;
  logic        wr_en = 1'b0;
  logic [15:0] wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic        wr_fault;
  logic        parity_err;

`ifdef IMEM_PARITY_EN
  localparam bit ParOn = 1'b1;
`else
  localparam bit ParOn = 1'b0;
`endif

  localparam logic [31:0] Img [4] = '{32'h6842000A, 32'h6885FFF0, 32'h48C81100, 32'h0FC64000};

  int errors = 0;
  int checks = 0;

  // Reference model state.
  logic [31:0] m_mem   [256];
  bit          m_known [256];
  bit          m_bad   [256];
  bit          m_ready = 1'b0;
  int          m_left  = 4;
  bit          exp_valid, exp_fault, exp_wrf, exp_perr, exp_dk;
  logic [31:0] exp_data;

  imem_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .boot_done   (boot_done),
    .fetch_req   (fetch_req),
    .fetch_addr  (fetch_addr),
    .fetch_valid (fetch_valid),
    .fetch_data  (fetch_data),
    .fetch_fault (fetch_fault),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .wr_fault    (wr_fault),
    .parity_err  (parity_err)
  );

  always #5 clk = ~clk;

  // Drive one cycle of inputs, advance the model across the edge, settle 1 ns after it.
  task automatic step(input bit rst, input bit fr, input logic [15:0] fa,
                      input bit we, input logic [15:0] wa, input logic [31:0] wd);
    reset = rst; fetch_req = fr; fetch_addr = fa; wr_en = we; wr_addr = wa; wr_data = wd;
    @(posedge clk);
    if (rst) begin
      m_ready = 1'b0; m_left = 4;
      exp_valid = 1'b0; exp_fault = 1'b0; exp_wrf = 1'b0; exp_perr = 1'b0;
      exp_data = '0; exp_dk = 1'b1;
    end else begin
      exp_valid = fr && m_ready;
      exp_perr  = 1'b0;
      if (exp_valid) begin
        if (fa < 16'd256) begin
          exp_data = m_mem[fa[7:0]]; exp_dk = m_known[fa[7:0]]; exp_fault = 1'b0;
          exp_perr = ParOn && m_bad[fa[7:0]];
        end else begin
          exp_data = '0; exp_dk = 1'b1; exp_fault = 1'b1;
        end
      end
      exp_wrf = we && m_ready && (wa >= 16'd256);
      if (we && m_ready && wa < 16'd256) begin
        m_mem[wa[7:0]] = wd; m_known[wa[7:0]] = 1'b1; m_bad[wa[7:0]] = 1'b0;
      end
      if (!m_ready) begin
        m_mem[4 - m_left] = Img[4 - m_left];
        m_known[4 - m_left] = 1'b1; m_bad[4 - m_left] = 1'b0;
        m_left--;
        if (m_left == 0) m_ready = 1'b1;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    step(1, 1, 16'd0, 1, 16'd0, 32'h1);
    step(1, 1, 16'd0, 1, 16'd0, 32'h1);
    checks++; if (boot_done !== 1'b0) begin errors++; $display("FAIL reset_boot_done got=%b want=0", boot_done); end
    checks++; if (fetch_valid !== 1'b0) begin errors++; $display("FAIL reset_fetch_valid got=%b want=0", fetch_valid); end
    checks++; if (fetch_fault !== 1'b0 || wr_fault !== 1'b0 || parity_err !== 1'b0) begin
      errors++; $display("FAIL reset_flags got=%b%b%b want=000", fetch_fault, wr_fault, parity_err);
    end
    checks++; if (fetch_data !== 32'h0) begin errors++; $display("FAIL reset_fetch_data got=%h want=0", fetch_data); end
  endtask

  task automatic test_boot();
    int cyc = 0;
    while (boot_done !== 1'b1 && cyc < 20) begin
      step(0, 1, 16'd0, 0, 16'd0, 32'h0);
      cyc++;
      checks++; if (fetch_valid !== exp_valid) begin
        errors++; $display("FAIL boot_fetch_valid cyc=%0d got=%b want=%b", cyc, fetch_valid, exp_valid);
      end
    end
    checks++; if (cyc != 4 || boot_done !== 1'b1) begin
      errors++; $display("FAIL boot_length got=%0d cycles done=%b want=4 done=1", cyc, boot_done);
    end
    step(0, 1, 16'd0, 0, 16'd0, 32'h0);
    checks++; if (fetch_valid !== 1'b1 || fetch_data !== 32'h6842000A) begin
      errors++; $display("FAIL boot_first_fetch got=%b/%h want=1/6842000a", fetch_valid, fetch_data);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 1; i < 4; i++) begin
      step(0, 1, 16'(i), 0, 16'd0, 32'h0);
      checks++; if (fetch_valid !== 1'b1 || fetch_fault !== 1'b0 || fetch_data !== Img[i]) begin
        errors++; $display("FAIL b2b_addr%0d got=%b/%b/%h want=1/0/%h", i, fetch_valid, fetch_fault,
                           fetch_data, Img[i]);
      end
    end
  endtask

  task automatic test_read_first();
    step(0, 0, 16'd0, 1, 16'd10, 32'h0BADF00D);
    step(0, 1, 16'd10, 1, 16'd10, 32'hDEADBEEF);
    checks++; if (fetch_data !== 32'h0BADF00D) begin
      errors++; $display("FAIL read_first_old got=%h want=0badf00d", fetch_data);
    end
    step(0, 1, 16'd10, 0, 16'd0, 32'h0);
    checks++; if (fetch_data !== 32'hDEADBEEF) begin
      errors++; $display("FAIL read_first_new got=%h want=deadbeef", fetch_data);
    end
  endtask

  task automatic test_range();
    step(0, 0, 16'd0, 1, 16'd44, 32'h44444444);
    step(0, 0, 16'd0, 1, 16'd255, 32'hFFFF0255);
    step(0, 0, 16'd0, 1, 16'd300, 32'h33333333);
    checks++; if (wr_fault !== 1'b1) begin errors++; $display("FAIL wr_fault_pulse got=%b want=1", wr_fault); end
    step(0, 1, 16'd44, 0, 16'd0, 32'h0);
    checks++; if (wr_fault !== 1'b0) begin errors++; $display("FAIL wr_fault_clear got=%b want=0", wr_fault); end
    checks++; if (fetch_data !== 32'h44444444) begin
      errors++; $display("FAIL no_alias got=%h want=44444444", fetch_data);
    end
    step(0, 1, 16'd255, 0, 16'd0, 32'h0);
    checks++; if (fetch_fault !== 1'b0 || fetch_data !== 32'hFFFF0255) begin
      errors++; $display("FAIL last_word got=%b/%h want=0/ffff0255", fetch_fault, fetch_data);
    end
    step(0, 1, 16'd256, 0, 16'd0, 32'h0);
    checks++; if (fetch_valid !== 1'b1 || fetch_fault !== 1'b1 || fetch_data !== 32'h0) begin
      errors++; $display("FAIL fetch_256 got=%b/%b/%h want=1/1/0", fetch_valid, fetch_fault, fetch_data);
    end
    step(0, 0, 16'd0, 0, 16'd0, 32'h0);
    checks++; if (fetch_valid !== 1'b0 || fetch_fault !== 1'b1 || fetch_data !== 32'h0) begin
      errors++; $display("FAIL fault_hold got=%b/%b/%h want=0/1/0", fetch_valid, fetch_fault, fetch_data);
    end
    step(0, 1, 16'hFFFF, 0, 16'd0, 32'h0);
    checks++; if (fetch_fault !== 1'b1 || fetch_data !== 32'h0) begin
      errors++; $display("FAIL fetch_ffff got=%b/%h want=1/0", fetch_fault, fetch_data);
    end
  endtask

  task automatic test_random();
    for (int a = 0; a < 256; a++) step(0, 0, 16'd0, 1, 16'(a), $urandom);
    for (int n = 0; n < 400; n++) begin
      step(0, 1'($urandom_range(0, 1)), 16'($urandom_range(0, 300)),
           1'($urandom_range(0, 1)), 16'($urandom_range(0, 300)), $urandom);
      checks++; if (fetch_valid !== exp_valid || wr_fault !== exp_wrf || fetch_fault !== exp_fault ||
                    (exp_dk && fetch_data !== exp_data) || (exp_valid && parity_err !== exp_perr)) begin
        errors++;
        $display("FAIL random_%0d got v=%b f=%b d=%h wf=%b pe=%b want v=%b f=%b d=%h wf=%b pe=%b", n,
                 fetch_valid, fetch_fault, fetch_data, wr_fault, parity_err,
                 exp_valid, exp_fault, exp_data, exp_wrf, exp_perr);
      end
    end
  endtask

  task automatic test_reset_mid_boot();
    logic [31:0] old20;
    step(0, 0, 16'd0, 1, 16'd1, 32'h12345678);
    step(0, 0, 16'd0, 1, 16'd10, 32'hDEADBEEF);
    old20 = m_mem[20];
    step(1, 1, 16'd20, 1, 16'd20, 32'hA5A5A5A5);
    checks++; if (fetch_valid !== 1'b0 || boot_done !== 1'b0) begin
      errors++; $display("FAIL reset_ready got=%b/%b want=0/0", fetch_valid, boot_done);
    end
    step(0, 0, 16'd0, 0, 16'd0, 32'h0);
    step(0, 0, 16'd0, 0, 16'd0, 32'h0);
    step(1, 0, 16'd0, 0, 16'd0, 32'h0);
    begin
      int cyc = 0;
      while (boot_done !== 1'b1 && cyc < 20) begin step(0, 0, 16'd0, 0, 16'd0, 32'h0); cyc++; end
      checks++; if (cyc != 4) begin errors++; $display("FAIL reboot_length got=%0d want=4", cyc); end
    end
    step(0, 1, 16'd1, 0, 16'd0, 32'h0);
    checks++; if (fetch_data !== 32'h6885FFF0) begin
      errors++; $display("FAIL reboot_addr1 got=%h want=6885fff0", fetch_data);
    end
    step(0, 1, 16'd10, 0, 16'd0, 32'h0);
    checks++; if (fetch_data !== 32'hDEADBEEF) begin
      errors++; $display("FAIL reboot_addr10 got=%h want=deadbeef", fetch_data);
    end
    step(0, 1, 16'd20, 0, 16'd0, 32'h0);
    checks++; if (fetch_data !== old20) begin
      errors++; $display("FAIL reset_drops_write got=%h want=%h", fetch_data, old20);
    end
  endtask

  task automatic test_parity();
    step(0, 0, 16'd0, 1, 16'd5, 32'h00000F0F);
    step(0, 1, 16'd5, 0, 16'd0, 32'h0);
    checks++; if (fetch_valid !== 1'b1 || parity_err !== 1'b0 || fetch_data !== 32'h00000F0F) begin
      errors++; $display("FAIL parity_clean got=%b/%b/%h want=1/0/00000f0f", fetch_valid, parity_err,
                         fetch_data);
    end
    dut.u_array.mem_q[5][0] <= ~dut.u_array.mem_q[5][0];
    #1;
    m_mem[5] = m_mem[5] ^ 32'h1; m_bad[5] = 1'b1;
    step(0, 1, 16'd5, 0, 16'd0, 32'h0);
    checks++; if (parity_err !== exp_perr || fetch_data !== 32'h00000F0E) begin
      errors++; $display("FAIL parity_flip got=%b/%h want=%b/00000f0e", parity_err, fetch_data, exp_perr);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_boot();
    test_back_to_back();
    test_read_first();
    test_range();
    test_random();
    test_reset_mid_boot();
    test_parity();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
